// File: rtl/fetch_linebuf.sv
// fetch_linebuf
//   Fetch-side line producer and realigner for the 64-bit instruction SRAM.
//   It issues line reads and holds up to two 64-bit lines: L0 is the line
//   that contains pc, and L1 is the line after it. Each cycle it presents one
//   raw instruction at pc. 16-bit instructions are passed through without
//   expansion. A 32-bit instruction that straddles two lines is stitched
//   together from L1[15:0] and L0[63:48].
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   jb, jb_pc           redirect pulse and target (bit0 ignored)
//   sram_cs, sram_addr  line read request, line address = byte addr[31:3]
//   sram_rdata          line data, valid the cycle after sram_cs
//   out_valid/out_ready presented-instruction handshake
//   out_pc, out_instr   PC and raw instruction bits
//   out_isrv16          presented instruction is 16-bit (out_instr[1:0]!=11)

module fetch_linebuf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jb,
    input  logic [31:0] jb_pc,
    output logic        sram_cs,
    output logic [28:0] sram_addr,
    input  logic [63:0] sram_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_isrv16
);

    logic [31:0] pc, pc_n;
    logic [28:0] fptr, fptr_n;
    logic [63:0] l0, l0_n, l1, l1_n;
    logic        l0_v, l0_v_n, l1_v, l1_v_n;
    logic        resp_pend, resp_pend_n;

    logic        accept;
    logic        line_pop;
    logic [31:0] pc_adv;
    logic [31:0] jb_tgt;
    logic [2:0]  occ_after;

    // Presented instruction: a pure mux of the slots selected by pc[2:1].
    always_comb begin
        case (pc[2:1])
            2'b00:   out_instr = l0[31:0];
            2'b01:   out_instr = l0[47:16];
            2'b10:   out_instr = l0[63:32];
            default: out_instr = {l1[15:0], l0[63:48]};
        endcase
        out_isrv16 = (out_instr[1:0] != 2'b11);
        // Only a 32-bit instruction at offset 6 needs the next line.
        out_valid  = l0_v && ((pc[2:1] != 2'b11) || (l0[49:48] != 2'b11) || l1_v);
        out_pc     = pc;
    end

    assign jb_tgt   = jb_pc & 32'hFFFF_FFFE;
    assign accept   = out_valid && out_ready && !jb;
    assign pc_adv   = pc + (out_isrv16 ? 32'd2 : 32'd4);
    assign line_pop = accept && (pc_adv[31:3] != pc[31:3]);

    // Lines held plus line in flight, after this cycle's pop. A pop always
    // implies L0 valid, so the subtraction cannot underflow.
    assign occ_after = {2'b00, l0_v} + {2'b00, l1_v} + {2'b00, resp_pend}
                     - {2'b00, line_pop};

    assign sram_cs   = !rst && !jb && (occ_after < 3'd2);
    assign sram_addr = fptr;

    always_comb begin
        pc_n        = pc;
        fptr_n      = fptr;
        l0_n        = l0;
        l1_n        = l1;
        l0_v_n      = l0_v;
        l1_v_n      = l1_v;
        resp_pend_n = sram_cs;
        if (jb) begin
            // Redirect wins over accept and response; in-flight line is dropped.
            pc_n        = jb_tgt;
            fptr_n      = jb_tgt[31:3];
            l0_v_n      = 1'b0;
            l1_v_n      = 1'b0;
            resp_pend_n = 1'b0;
        end else begin
            if (accept) begin
                pc_n = pc_adv;
            end
            if (line_pop) begin
                l0_n   = l1;
                l0_v_n = l1_v;
                l1_v_n = 1'b0;
            end
            // Response fills the first slot that is empty after any pop.
            if (resp_pend) begin
                if (!l0_v_n) begin
                    l0_n   = sram_rdata;
                    l0_v_n = 1'b1;
                end else begin
                    l1_n   = sram_rdata;
                    l1_v_n = 1'b1;
                end
            end
            if (sram_cs) begin
                fptr_n = fptr + 29'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            fptr      <= RESET_PC[31:3];
            l0        <= 64'h0;
            l1        <= 64'h0;
            l0_v      <= 1'b0;
            l1_v      <= 1'b0;
            resp_pend <= 1'b0;
        end else begin
            pc        <= pc_n;
            fptr      <= fptr_n;
            l0        <= l0_n;
            l1        <= l1_n;
            l0_v      <= l0_v_n;
            l1_v      <= l1_v_n;
            resp_pend <= resp_pend_n;
        end
    end

endmodule

// File: tb/tb_fetch_linebuf.sv
module tb_fetch_linebuf;

    logic        clk = 1'b0;
    logic        rst;
    logic        jb;
    logic [31:0] jb_pc;
    logic        sram_cs;
    logic [28:0] sram_addr;
    logic [63:0] sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_isrv16;

    always #5 clk = ~clk;

    fetch_linebuf #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .jb         (jb),
        .jb_pc      (jb_pc),
        .sram_cs    (sram_cs),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_isrv16 (out_isrv16)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rv16;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc_cnt  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory as halfwords. Below 0x100 every instruction is
    // 32-bit; 0x300..0x309 is a hand-written mixed sequence; elsewhere a hash.
    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] t;
        case (a)
            32'h300: return 16'h0001;
            32'h302: return 16'h0001;
            32'h304: return 16'h0013;
            32'h306: return 16'h0000;
            32'h308: return 16'h4501;
            default: ;
        endcase
        if (a < 32'h100) return {a[15:2] + 14'h123, 2'b11};
        t = a * 32'h9E37_79B1;
        return t[31:16];
    endfunction

    function automatic logic [63:0] mem_line(input logic [28:0] la);
        logic [31:0] b;
        b = {la, 3'b000};
        return {hw(b + 32'd6), hw(b + 32'd4), hw(b + 32'd2), hw(b)};
    endfunction

    // Expected instruction stream from a start PC, walked through memory.
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] p;
        logic [15:0] h;
        exp_t        e;
        sb.delete();
        p = start & 32'hFFFF_FFFE;
        repeat (256) begin
            h = hw(p);
            e.pc = p;
            if (h[1:0] != 2'b11) begin
                e.instr = {16'h0, h};
                e.rv16  = 1'b1;
                p = p + 32'd2;
            end else begin
                e.instr = {hw(p + 32'd2), h};
                e.rv16  = 1'b0;
                p = p + 32'd4;
            end
            sb.push_back(e);
        end
    endtask

    // SRAM with fixed one-cycle latency; unrequested cycles return junk.
    logic        req_q  = 1'b0;
    logic [28:0] addr_q = '0;
    always @(negedge clk) begin
        req_q  = sram_cs;
        addr_q = sram_addr;
    end
    always @(posedge clk) begin
        #1;
        sram_rdata = req_q ? mem_line(addr_q) : 64'hDEAD_BEEF_0BAD_F00D;
    end

    // Scoreboard: pop and compare on every accepted instruction.
    exp_t        mon_e;
    logic [31:0] mon_instr;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !jb) begin
            acc_cnt++;
            if (sb.size() == 0) begin
                check_val("sb_underflow", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                mon_instr = out_isrv16 ? {16'h0, out_instr[15:0]} : out_instr;
                check_val("out_pc", out_pc, mon_e.pc);
                check_val("out_isrv16", out_isrv16, mon_e.rv16);
                check_val("out_instr", mon_instr, mon_e.instr);
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) drive_edge();
    endtask

    task automatic reset_seq(input int n);
        drive_edge();
        rst = 1'b1;
        jb  = 1'b0;
        load_stream(32'h0);
        for (int i = 0; i < n; i++) begin
            nedge();
            check_val("rst_cs", sram_cs, 0);
            if (i > 0) check_val("rst_valid", out_valid, 0);
        end
        drive_edge();
        rst = 1'b0;
        nedge();
        check_val("rel_cs0", sram_cs, 1);
        check_val("rel_addr0", sram_addr, 29'h0);
        check_val("rel_valid0", out_valid, 0);
        nedge();
        check_val("rel_cs1", sram_cs, 1);
        check_val("rel_addr1", sram_addr, 29'h1);
        check_val("rel_valid1", out_valid, 0);
        nedge();
        check_val("rel_valid2", out_valid, 1);
        check_val("rel_pc2", out_pc, 32'h0);
    endtask

    // Redirect with timing checks; v_at_t returns out_valid in the jb cycle.
    task automatic redirect_check(input logic [31:0] tgt, input bit straddle, output logic v_at_t);
        drive_edge();
        jb    = 1'b1;
        jb_pc = tgt;
        load_stream(tgt);
        nedge();
        v_at_t = out_valid;
        check_val("jb_cs_t0", sram_cs, 0);
        drive_edge();
        jb = 1'b0;
        nedge();
        check_val("jb_cs_t1", sram_cs, 1);
        check_val("jb_addr_t1", sram_addr, {3'b000, tgt[31:3]});
        check_val("jb_valid_t1", out_valid, 0);
        nedge();
        check_val("jb_valid_t2", out_valid, 0);
        nedge();
        if (straddle) begin
            check_val("jb_valid_t3_straddle", out_valid, 0);
            nedge();
        end
        check_val("jb_valid_out", out_valid, 1);
        check_val("jb_pc_out", out_pc, tgt & 32'hFFFF_FFFE);
    endtask

    logic        v_t;
    int          a0;
    int          cs_cnt;
    bit          have_snap;
    logic [31:0] snap_pc, snap_instr;

    initial begin
        rst        = 1'b1;
        jb         = 1'b0;
        jb_pc      = 32'h0;
        out_ready  = 1'b1;
        sram_rdata = 64'h0;

        // Reset and all-32-bit stream at one instruction per cycle.
        reset_seq(3);
        a0 = acc_cnt;
        repeat (16) nedge();
        check_val("throughput", acc_cnt - a0, 16);

        // Redirect during an accept to a straddling 32-bit target at 0x6.
        redirect_check(32'h0000_0006, 1'b1, v_t);
        check_val("jb_with_accept", v_t, 1);
        run(12);

        // Redirect with a line in flight; the stale line must never appear.
        redirect_check(32'h0000_0100, 1'b0, v_t);
        run(12);

        // Mixed 16/32-bit sequence.
        redirect_check(32'h0000_0300, 1'b0, v_t);
        run(12);

        // Random ready with occasional random redirects.
        a0 = acc_cnt;
        for (int i = 0; i < 200; i++) begin
            drive_edge();
            if ($urandom_range(0, 39) == 0) begin
                jb    = 1'b1;
                jb_pc = $urandom;
                load_stream(jb_pc);
            end else begin
                jb = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drive_edge();
        jb        = 1'b0;
        out_ready = 1'b1;
        check_val("random_progress", (acc_cnt - a0) > 60, 1);
        run(8);

        // Ten-cycle stall: outputs hold, requests stop at capacity.
        cs_cnt    = 0;
        have_snap = 1'b0;
        snap_pc    = '0;
        snap_instr = '0;
        for (int k = 0; k < 10; k++) begin
            drive_edge();
            out_ready = 1'b0;
            nedge();
            cs_cnt += int'(sram_cs);
            if (k >= 2) check_val("stall_cs", sram_cs, 0);
            if (have_snap) begin
                check_val("stall_valid", out_valid, 1);
                check_val("stall_pc", out_pc, snap_pc);
                check_val("stall_instr", out_instr, snap_instr);
            end else if (out_valid) begin
                have_snap  = 1'b1;
                snap_pc    = out_pc;
                snap_instr = out_instr;
            end
        end
        check_val("stall_req_le2", cs_cnt <= 2, 1);
        check_val("stall_held", have_snap, 1);
        drive_edge();
        out_ready = 1'b1;
        run(20);

        // Wrap past 0xFFFF_FFFF into low memory.
        redirect_check(32'hFFFF_FFF0, 1'b0, v_t);
        run(24);
        nedge();
        check_val("wrap_pc_low", out_pc < 32'h100, 1);

        // Reset in the middle of streaming.
        reset_seq(2);
        run(15);
        nedge();
        check_val("post_reset_progress", out_pc > 32'h20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
